guineveer_sram_mp: RTL and testbench
====================================

# guineveer_sram_mp

Multi-port, word-interleaved, banked SRAM model for the Guineveer memory subsystem. It sits behind one or more AXI-to-memory converters, one per requester, and serves each converter's memory-side request/grant/rvalid port. Compared with the single-bank SRAM it adds:
- configurable banks and ports, with fixed-priority bank-conflict arbitration;
- a configurable read-latency pipeline;
- strobes that scale with DATA_WIDTH;
- an optional post-reset zero-fill state machine and a conflict counter.

## Interface
- ADDR_WIDTH, 32: byte-address width of each port.
- DATA_WIDTH, 64: word width; a power of two, at least 8. STRB_WIDTH = DATA_WIDTH/8.
- DEPTH_WORDS, 4096: total words; a power of two and a multiple of NUM_BANKS.
- NUM_BANKS, 2: number of banks; a power of two, at least 1.
- NUM_PORTS, 2: number of request ports, 1..8.
- READ_LATENCY, 1: cycles from grant to rvalid, 1..3.
- INIT_ZERO, 1: 1 means zero-fill all words after reset.

Ports:
- clk_i in 1: the single clock.
- rst_i in 1: synchronous, active-high reset.
- req_i in NUM_PORTS: request per port.
- gnt_o out NUM_PORTS: grant per port; combinational.
- addr_i in NUM_PORTS×ADDR_WIDTH: byte address per port.
- we_i in NUM_PORTS: write enable per port.
- strb_i in NUM_PORTS×STRB_WIDTH: byte strobes per port.
- wdata_i in NUM_PORTS×DATA_WIDTH: write data per port.
- rvalid_o out NUM_PORTS: response valid per port.
- rdata_o out NUM_PORTS×DATA_WIDTH: response data per port.
- init_done_o out 1: high once the memory accepts requests.
- conflict_cnt_o out 32: saturating count of denied requests.

## Operation
- Address decode:
  - word = addr_i >> log2(STRB_WIDTH)
  - bank = word mod NUM_BANKS
  - row = (word / NUM_BANKS) mod (DEPTH_WORDS/NUM_BANKS)
  - Upper address bits beyond the row field are ignored, so the memory aliases.
- Arbitration:
  - gnt_o[p] = req_i[p] & init_done_o & no port q<p with req_i[q] targeting the same bank.
  - Lowest port index wins. Non-conflicting ports are granted in parallel.
- Granted access executes at the rising edge.
  - Reads are read-before-write: rdata returns the row content before any same-edge write.
  - Writes update only the bytes whose strb bit is set.
- Every granted request, read or write, produces exactly one rvalid on its own port. rdata carries the pre-access word for both reads and writes.
- Each denied request (req_i[p] & !gnt_o[p] while init_done_o) increments conflict_cnt_o by 1 per port per cycle. The count saturates at 0xFFFF_FFFF.
- State machine:
  - RESET: entered while rst_i is high.
  - RESET → INIT when INIT_ZERO=1. INIT writes zero to row r of all banks each cycle, r = 0..DEPTH_WORDS/NUM_BANKS−1, then moves to READY.
  - RESET → READY directly when INIT_ZERO=0.
  - init_done_o is high only in READY.
- When the GUINEVEER_MEMORY_FILE define is set, the array is preloaded by $readmemh at time 0 in flat word order (word w maps to bank w mod NUM_BANKS). A preload requires INIT_ZERO=0, otherwise INIT overwrites it.
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, init_done_o=0, conflict_cnt_o=0. Array contents are not reset.

## Timing
- A grant in cycle N gives rvalid_o[p]=1 in cycle N+READ_LATENCY for exactly one cycle, with rdata_o valid in that cycle. rdata_o holds its last value otherwise.
- Throughput is one access per port per cycle with no bubbles. Pipeline stages are per port and independent.
- Two ports accessing the same bank never both complete; the loser gets gnt_o=0 and must hold its request.
- A write to row X in cycle N followed by a read of X in cycle N+1 returns the new data.
- INIT duration:
  - INIT_ZERO=1: init_done_o rises DEPTH_WORDS/NUM_BANKS cycles after the first cycle with rst_i low.
  - INIT_ZERO=0: init_done_o rises 1 cycle after that cycle.
- While init_done_o is low, requests are ignored: no grant, no counting.
- rst_i asserted mid-operation:
  - All in-flight rvalids are dropped; no rvalid for accesses granted before the reset.
  - INIT restarts from row 0.
  - conflict_cnt_o clears to 0.
- The bank is a function of the current addr_i only; there is no hazard tracking across ports.

## Test plan
- Zero-fill: use DEPTH_WORDS=64, NUM_BANKS=2, INIT_ZERO=1. Release reset; init_done_o must rise exactly 32 cycles later. Then read every word → 0.
- Byte strobes: write 0x1122334455667788 with strb=0xFF to addr 0x40. Then write 0xAAAA… with strb=0x0F to the same address. A read must return 0x11223344AAAAAAAA.
- Read latency:
  - With READ_LATENCY=3, read addr 0x8 at cycle N → rvalid at N+3 carrying the old data.
  - Back-to-back reads on 4 consecutive cycles → 4 consecutive rvalids.
- Conflict: ports 0 and 1 both request bank 0 (addr 0x0 and 0x10) for 3 cycles. Required: gnt_o=01 each cycle and conflict_cnt_o=3. With port 1 moved to addr 0x8 (bank 1), gnt_o=11.
- Same-edge read/write: port 0 writes 0xDEAD to row X while port 1 (fixed priority) is denied on the same bank. The next cycle's read of X returns 0xDEAD.
- Reset mid-read: assert rst_i one cycle after a grant with READ_LATENCY=2. No rvalid may appear, and conflict_cnt_o must read 0.

Source files
------------

// File: rtl/guineveer_sram_mp_if.sv
// Memory-side request/grant/rvalid bundle for all ports of guineveer_sram_mp.
interface guineveer_sram_mp_if #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [NUM_PORTS-1:0]                 req_i;
    logic [NUM_PORTS-1:0]                 gnt_o;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_i;
    logic [NUM_PORTS-1:0]                 we_i;
    logic [NUM_PORTS-1:0][STRB_WIDTH-1:0] strb_i;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_i;
    logic [NUM_PORTS-1:0]                 rvalid_o;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_o;

    modport master (
        output req_i, addr_i, we_i, strb_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, addr_i, we_i, strb_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/guineveer_sram_mp.sv
// Multi-port, word-interleaved banked SRAM with fixed-priority bank arbitration,
// per-port read-latency pipeline, optional post-reset zero fill and conflict counter.
module guineveer_sram_mp #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned DEPTH_WORDS  = 4096,
    parameter int unsigned NUM_BANKS    = 2,
    parameter int unsigned NUM_PORTS    = 2,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned INIT_ZERO    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    guineveer_sram_mp_if.slave   mem,
    output logic                 init_done_o,
    output logic [31:0]          conflict_cnt_o
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned OFF_W      = $clog2(STRB_WIDTH);
    localparam int unsigned ROWS       = DEPTH_WORDS / NUM_BANKS;
    localparam int unsigned BANK_BITS  = $clog2(NUM_BANKS);
    localparam int unsigned BANK_W     = (BANK_BITS == 0) ? 1 : BANK_BITS;
    localparam int unsigned ROW_BITS   = $clog2(ROWS);
    localparam int unsigned ROW_W      = (ROW_BITS == 0) ? 1 : ROW_BITS;
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_READY} state_t;

    state_t                               r_state, w_state_nxt;
    logic [ROW_W-1:0]                     r_init_row, w_init_row_nxt;
    logic                                 w_fill_en;
    logic [ROW_W-1:0]                     w_fill_row;
    logic                                 w_ready;

    logic [DATA_WIDTH-1:0]                r_mem [NUM_BANKS][ROWS];
    logic [NUM_PORTS-1:0][IDX_W-1:0]      w_idx;
    logic [NUM_PORTS-1:0][BANK_W-1:0]     w_bank;
    logic [NUM_PORTS-1:0][ROW_W-1:0]      w_row;
    logic [NUM_PORTS-1:0]                 w_blk;
    logic [NUM_PORTS-1:0]                 w_gnt;
    logic [NUM_PORTS-1:0]                 w_deny;
    logic [DATA_WIDTH-1:0]                w_rd_word [NUM_PORTS];

    logic [NUM_PORTS-1:0][READ_LATENCY-1:0] r_vld;
    logic [DATA_WIDTH-1:0]                r_dat [NUM_PORTS][READ_LATENCY];
    logic [31:0]                          r_cnt;
    logic [32:0]                          w_cnt_sum;

    // State register; the fill row counter travels with it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_RESET;
            r_init_row <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_row <= w_init_row_nxt;
        end
    end

    // Row 0 is zeroed on the edge leaving RESET so READY lands exactly ROWS cycles after release.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_row_nxt = r_init_row;
        w_fill_en      = 1'b0;
        w_fill_row     = '0;
        case (r_state)
            ST_RESET: begin
                if (INIT_ZERO != 0) begin
                    w_fill_en = !rst_i;
                    if (ROWS > 1) begin
                        w_state_nxt    = ST_INIT;
                        w_init_row_nxt = ROW_W'(1);
                    end else begin
                        w_state_nxt = ST_READY;
                    end
                end else begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_INIT: begin
                w_fill_en      = !rst_i;
                w_fill_row     = r_init_row;
                w_init_row_nxt = r_init_row + ROW_W'(1);
                if (r_init_row == ROW_W'(ROWS - 1)) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: ;
            default:  w_state_nxt = ST_RESET;
        endcase
    end

    assign init_done_o    = (r_state == ST_READY);
    assign w_ready        = init_done_o & ~rst_i;
    assign conflict_cnt_o = r_cnt;

    // Interleaved decode: low word bits pick the bank, the next bits the row; the rest alias.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_idx[p]  = IDX_W'(mem.addr_i[p] >> OFF_W);
            w_bank[p] = (NUM_BANKS > 1) ? BANK_W'(w_idx[p]) : '0;
            w_row[p]  = (ROWS > 1) ? ROW_W'(w_idx[p] >> BANK_BITS) : '0;
        end
    end

    // Fixed priority: any lower-index requester on the same bank blocks this port.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_blk[p] = 1'b0;
            for (int q = 0; q < p; q++) begin
                if (mem.req_i[q] && (w_bank[q] == w_bank[p])) begin
                    w_blk[p] = 1'b1;
                end
            end
            w_gnt[p]     = mem.req_i[p] & w_ready & ~w_blk[p];
            w_rd_word[p] = r_mem[w_bank[p]][w_row[p]];
        end
        w_deny    = mem.req_i & ~w_gnt & {NUM_PORTS{w_ready}};
        w_cnt_sum = 33'(r_cnt) + 33'($countones(w_deny));
    end

    assign mem.gnt_o = w_gnt;

    // Array is not reset; grants never coincide with the zero fill.
    always_ff @(posedge clk_i) begin
        if (w_fill_en) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_mem[b][w_fill_row] <= '0;
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_gnt[p] && mem.we_i[p]) begin
                for (int j = 0; j < STRB_WIDTH; j++) begin
                    if (mem.strb_i[p][j]) begin
                        r_mem[w_bank[p]][w_row[p]][j*8 +: 8] <= mem.wdata_i[p][j*8 +: 8];
                    end
                end
            end
        end
    end

    // Per-port response pipeline; data stages only load behind a valid so rdata holds.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int k = 0; k < READ_LATENCY; k++) begin
                    r_dat[p][k] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_vld[p][0] <= w_gnt[p];
                if (w_gnt[p]) begin
                    r_dat[p][0] <= w_rd_word[p];
                end
                for (int k = 1; k < READ_LATENCY; k++) begin
                    r_vld[p][k] <= r_vld[p][k-1];
                    if (r_vld[p][k-1]) begin
                        r_dat[p][k] <= r_dat[p][k-1];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            mem.rvalid_o[p] = r_vld[p][READ_LATENCY-1];
            mem.rdata_o[p]  = r_dat[p][READ_LATENCY-1];
        end
    end

    // Saturating count of denied requests.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_sum[32] ? 32'hFFFF_FFFF : w_cnt_sum[31:0];
        end
    end
endmodule

// File: tb/tb_guineveer_sram_mp.sv
// Scoreboard bench for guineveer_sram_mp: flat-array reference model, randomized traffic.
module tb_guineveer_sram_mp;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned NB    = 2;
    localparam int unsigned NP    = 2;
    localparam int unsigned RL    = 3;
    localparam int unsigned SW    = DW / 8;

    typedef struct packed {
        logic [31:0] due;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic [31:0] cnt;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    guineveer_sram_mp_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    guineveer_sram_mp #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH), .NUM_BANKS(NB),
        .NUM_PORTS(NP), .READ_LATENCY(RL), .INIT_ZERO(1)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .mem(bus),
        .init_done_o(init_done),
        .conflict_cnt_o(cnt)
    );

    logic [63:0] model_mem [DEPTH];
    logic [31:0] model_cnt;
    exp_t        sb [NP][$];
    logic [63:0] last_rdata [NP];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [NP-1:0] t_req, t_we;
    logic [AW-1:0] t_addr  [NP];
    logic [SW-1:0] t_strb  [NP];
    logic [DW-1:0] t_wdata [NP];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_stim();
        t_req = '0;
        t_we  = '0;
        for (int p = 0; p < NP; p++) begin
            t_addr[p]  = '0;
            t_strb[p]  = '0;
            t_wdata[p] = '0;
        end
    endtask

    // One bus cycle: drive, predict grants from the bank rule, enqueue expected responses.
    task automatic step();
        logic [NP-1:0] eg;
        int unsigned   w [NP];
        bus.req_i = t_req;
        bus.we_i  = t_we;
        for (int p = 0; p < NP; p++) begin
            bus.addr_i[p]  = t_addr[p];
            bus.strb_i[p]  = t_strb[p];
            bus.wdata_i[p] = t_wdata[p];
            w[p] = (t_addr[p] >> 3) % DEPTH;
        end
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            eg[p] = t_req[p];
            for (int q = 0; q < p; q++) begin
                if (t_req[q] && ((w[q] % NB) == (w[p] % NB))) eg[p] = 1'b0;
            end
        end
        chk("gnt", 64'(bus.gnt_o), 64'(eg));
        chk("conflict_cnt", 64'(cnt), 64'(model_cnt));
        for (int p = 0; p < NP; p++) begin
            if (eg[p]) sb[p].push_back('{due: cyc + RL, data: model_mem[w[p]]});
        end
        for (int p = 0; p < NP; p++) begin
            if (eg[p] && t_we[p]) begin
                for (int j = 0; j < SW; j++) begin
                    if (t_strb[p][j]) model_mem[w[p]][j*8 +: 8] = t_wdata[p][j*8 +: 8];
                end
            end
            if (t_req[p] && !eg[p]) model_cnt = model_cnt + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        clear_stim();
        repeat (RL + 2) step();
    endtask

    // Called #1 after the edge that starts the first cycle with rst low.
    task automatic wait_init(input bit drive_req);
        int k = 0;
        @(negedge clk);
        while (!init_done && k < 200) begin
            if (drive_req) chk("gnt_during_init", 64'(bus.gnt_o), 64'd0);
            @(posedge clk);
            #1;
            k++;
            if (k == 10) bus.req_i = '0;
            @(negedge clk);
        end
        chk("init_cycles", 64'(k), 64'(DEPTH / NB));
        chk("cnt_after_init", 64'(cnt), 64'd0);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_cnt = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH / 2; i++) begin
            t_req     = 2'b11;
            t_we      = '0;
            t_addr[0] = AW'((2 * i) * 8);
            t_addr[1] = AW'((2 * i + 1) * 8);
            step();
        end
        drain();
    endtask

    // Response monitor: every rvalid must match the oldest outstanding expectation on that port.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (bus.rvalid_o[p] === 1'b1) begin
                    last_rdata[p] = bus.rdata_o[p];
                    if (sb[p].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rvalid_unexpected port=%0d actual=1 required=0 (cycle %0d)", p, cyc);
                    end else begin
                        e = sb[p].pop_front();
                        chk("rvalid_cycle", 64'(cyc), 64'(e.due));
                        chk("rdata", bus.rdata_o[p], e.data);
                    end
                end else if (sb[p].size() != 0 && sb[p][0].due <= cyc) begin
                    e = sb[p].pop_front();
                    chk("rvalid_missing", 64'd0, 64'd1);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] r;
        rst = 1'b1;
        clear_stim();
        model_cnt = '0;
        bus.req_i = 2'b11;
        bus.we_i  = '0;
        bus.addr_i[0] = 32'h0;
        bus.addr_i[1] = 32'h10;
        for (int p = 0; p < NP; p++) begin
            bus.strb_i[p]  = '0;
            bus.wdata_i[p] = '0;
            last_rdata[p]  = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt", 64'(bus.gnt_o), 64'd0);
        chk("reset_rvalid", 64'(bus.rvalid_o), 64'd0);
        chk("reset_rdata0", bus.rdata_o[0], 64'd0);
        chk("reset_rdata1", bus.rdata_o[1], 64'd0);
        chk("reset_init_done", 64'(init_done), 64'd0);
        chk("reset_cnt", 64'(cnt), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_init(1'b1);

        // Bank-0 conflict for three cycles, then port 1 moves to bank 1.
        t_req = 2'b11; t_addr[0] = 32'h0; t_addr[1] = 32'h10;
        repeat (3) step();
        chk("conflict_cnt_3", 64'(cnt), 64'd3);
        t_addr[1] = 32'h8;
        step();
        chk("conflict_cnt_hold", 64'(cnt), 64'd3);
        drain();

        read_all();

        // Byte-strobe merge.
        clear_stim();
        t_req = 2'b01; t_we = 2'b01; t_addr[0] = 32'h40;
        t_strb[0] = 8'hFF; t_wdata[0] = 64'h1122334455667788;
        step();
        t_strb[0] = 8'h0F; t_wdata[0] = 64'hAAAAAAAAAAAAAAAA;
        step();
        t_we = '0;
        step();
        drain();
        chk("strb_merge", last_rdata[0], 64'h11223344AAAAAAAA);

        // Single read then four back-to-back reads.
        t_req = 2'b01; t_addr[0] = 32'h8;
        step();
        drain();
        t_req = 2'b01;
        for (int i = 0; i < 4; i++) begin
            t_addr[0] = AW'(32'h8 + i * 16);
            step();
        end
        drain();

        // Port 0 writes while port 1 is denied on the same bank; next-cycle read sees it.
        t_req = 2'b11; t_we = 2'b01; t_addr[0] = 32'h20; t_addr[1] = 32'h30;
        t_strb[0] = 8'hFF; t_wdata[0] = 64'hDEAD;
        step();
        t_req = 2'b01; t_we = '0;
        step();
        drain();
        chk("write_then_read", last_rdata[0], 64'hDEAD);

        // Random traffic with aliased addresses.
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NP; p++) begin
                t_req[p] = ($urandom_range(0, 3) != 0);
                t_we[p]  = $urandom_range(0, 1) != 0;
                r = $urandom();
                t_addr[p] = r;
                t_strb[p] = SW'($urandom());
                t_wdata[p] = {$urandom(), $urandom()};
            end
            step();
        end
        drain();

        // Reset one cycle after a grant: the response must never appear.
        t_req = 2'b01; t_addr[0] = 32'h40;
        step();
        rst = 1'b1;
        clear_stim();
        bus.req_i = '0;
        for (int p = 0; p < NP; p++) sb[p].delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rvalid_in_reset", 64'(bus.rvalid_o), 64'd0);
            if (i > 0) chk("cnt_in_reset", 64'(cnt), 64'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        wait_init(1'b0);
        read_all();

        for (int p = 0; p < NP; p++) chk("scoreboard_empty", 64'(sb[p].size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
